// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared word width, underrun word and FSM encoding for the SPI responder
package spi_slave_pkg;
  localparam int SPI_DATA_W = 8;
  localparam logic [SPI_DATA_W-1:0] SPI_DEFAULT_TX = 8'h00;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchroniser plus a history flop that yields rise/fall pulses
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] sync_q;
  always_ff @(posedge clk)
    if (rst) sync_q <= {3{RST_VAL}};
    else sync_q <= {sync_q[1:0], d_i};
  assign q_o = sync_q[1];
  assign rise_o = sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/spi_slave.sv
// spi_slave: mode-0 SPI responder oversampled on m_clk with a one-word tx holding buffer
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter logic [DATA_W-1:0] DEFAULT_TX = SPI_DEFAULT_TX
) (
  input  logic              m_clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W);
  logic sclk_s, sclk_rise, sclk_fall, cs_s, cs_rise, cs_fall, mosi_s, mosi_rise, mosi_fall, unused;
  logic [0:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d, buf_q, buf_d, rx_data_q, rx_data_d, next_word;
  logic full_q, full_d, reload_q, reload_d, miso_q, miso_d, rx_valid_q, rx_valid_d, under_q, under_d;
  logic active, start, stop, rise, fall, load, wr, done;
  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (.clk(m_clk), .rst(rst), .d_i(spi_clk), .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_sync_edge #(.RST_VAL(1'b1)) u_cs (.clk(m_clk), .rst(rst), .d_i(spi_cs), .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall));
  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (.clk(m_clk), .rst(rst), .d_i(spi_mosi), .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall));
  assign unused = ^{sclk_s, cs_s, mosi_rise, mosi_fall};
  assign active = state_q == ST_ACTIVE;
  assign start = !active && cs_fall;
  assign stop = active && cs_rise;
  // CS release outranks a coincident SCLK edge, so the trailing fall of a frame never reloads
  assign rise = active && !cs_rise && sclk_rise;
  assign fall = active && !cs_rise && sclk_fall;
  assign load = start || (fall && reload_q);
  assign wr = tx_valid && !full_q;
  assign next_word = full_q ? buf_q : DEFAULT_TX;
  assign done = rise && cnt_q == CW'(DATA_W - 1);
  always_comb begin
    state_d = start ? ST_ACTIVE : stop ? ST_IDLE : state_q;
    full_d = wr || (full_q && !load);
    buf_d = wr ? tx_data : buf_q;
    under_d = load && !full_q;
    tx_sh_d = load ? next_word : fall ? tx_sh_q << 1 : tx_sh_q;
    miso_d = load ? next_word[DATA_W-1] : fall ? tx_sh_q[DATA_W-2] : stop ? 1'b0 : miso_q;
    rx_sh_d = rise ? {rx_sh_q[DATA_W-2:0], mosi_s} : rx_sh_q;
    rx_valid_d = done;
    rx_data_d = done ? rx_sh_d : rx_data_q;
    cnt_d = (start || stop || done) ? '0 : rise ? cnt_q + 1'b1 : cnt_q;
    reload_d = done ? 1'b1 : (load || stop) ? 1'b0 : reload_q;
  end
  always_ff @(posedge m_clk)
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      rx_sh_q <= '0;
      tx_sh_q <= '0;
      buf_q <= '0;
      rx_data_q <= '0;
      full_q <= 1'b0;
      reload_q <= 1'b0;
      miso_q <= 1'b0;
      rx_valid_q <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rx_sh_q <= rx_sh_d;
      tx_sh_q <= tx_sh_d;
      buf_q <= buf_d;
      rx_data_q <= rx_data_d;
      full_q <= full_d;
      reload_q <= reload_d;
      miso_q <= miso_d;
      rx_valid_q <= rx_valid_d;
      under_q <= under_d;
    end
  assign spi_miso = miso_q;
  assign spi_miso_oe = active;
  assign busy = active;
  assign tx_ready = !full_q;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_underrun = under_q;
endmodule
